// File: rtl/sdram_pkg.sv
// sdram_pkg: command codes and arbiter state encoding shared by the
// SDRAM controller, command sequencer and sdram_arbiter.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP     = 4'b0000;
  localparam logic [3:0] CMD_READ    = 4'b0001;
  localparam logic [3:0] CMD_WRITE   = 4'b0010;
  localparam logic [3:0] CMD_REFRESH = 4'b0011;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       in   request vector
//   ptr       in   index of the last winner; search starts at ptr+1
//   grant     out  one-hot winner (all zero when nothing requests)
//   grant_idx out  binary index of the winner
//   any_grant out  some request was found
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_grant && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller between NUM_REQ requesters.
// Round-robin grant, periodic auto-refresh at top priority, one command
// outstanding at the controller.
//   clk, rst               clock, synchronous active-high reset
//   init_comp              controller init finished (level, used once)
//   req_valid/cmd/addr/wdata  packed requester commands ([i*W +: W])
//   req_ready              one-hot capture strobe (combinational in IDLE)
//   rsp_done/rsp_rdata     one-hot completion pulse with read data
//   ctrl_valid/cmd/addr/wdata  command strobe and held fields to controller
//   ctrl_done/ctrl_rdata   controller completion with read data
//   busy                   command in progress
//   refresh_overrun        sticky: refresh interval expired while pending
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 22,
  parameter int DATA_W         = 16,
  parameter int CMD_W          = 4,
  parameter int REFRESH_CYCLES = 780
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_comp,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_done,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    ctrl_valid,
  output logic [CMD_W-1:0]        ctrl_cmd,
  output logic [ADDR_W-1:0]       ctrl_addr,
  output logic [DATA_W-1:0]       ctrl_wdata,
  input  logic                    ctrl_done,
  input  logic [DATA_W-1:0]       ctrl_rdata,
  output logic                    busy,
  output logic                    refresh_overrun
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0]   PTR_RESET  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_LSB    = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t state, state_n;

  logic [IDX_W-1:0]   rr_ptr, win_idx, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic               is_refresh;
  logic [CNT_W-1:0]   ref_cnt;
  logic               ref_pending, ref_expire;
  logic [DATA_W-1:0]  rdata_q;
  logic [CMD_W-1:0]   sel_cmd;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_mem, take_refresh, take_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign sel_cmd   = req_cmd[int'(grant_idx)*CMD_W +: CMD_W];
  assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_mem   = (sel_cmd == CMD_W'(CMD_READ)) || (sel_cmd == CMD_W'(CMD_WRITE));

  assign ref_expire = (state != ST_WAIT_INIT) && (ref_cnt == '0);

  always_comb begin
    state_n      = state;
    req_ready    = '0;
    take_refresh = 1'b0;
    take_grant   = 1'b0;
    case (state)
      ST_WAIT_INIT: if (init_comp) state_n = ST_IDLE;
      ST_IDLE: begin
        if (ref_pending) begin
          take_refresh = 1'b1;
          state_n      = ST_ISSUE;
        end else if (any_grant) begin
          take_grant = 1'b1;
          req_ready  = grant;
          state_n    = sel_mem ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE:     state_n = ST_WAIT_DONE;
      ST_WAIT_DONE: if (ctrl_done) state_n = is_refresh ? ST_IDLE : ST_RESP;
      ST_RESP:      state_n = ST_IDLE;
      default:      state_n = ST_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_WAIT_INIT;
      rr_ptr          <= PTR_RESET;
      win_idx         <= '0;
      is_refresh      <= 1'b0;
      ref_cnt         <= CNT_RELOAD;
      ref_pending     <= 1'b0;
      refresh_overrun <= 1'b0;
      ctrl_cmd        <= CMD_W'(CMD_NOP);
      ctrl_addr       <= '0;
      ctrl_wdata      <= '0;
      rdata_q         <= '0;
    end else begin
      state <= state_n;

      if (state != ST_WAIT_INIT)
        ref_cnt <= ref_expire ? CNT_RELOAD : ref_cnt - CNT_W'(1);

      // A fresh expiry wins over the clear from taking the refresh.
      if (ref_expire) begin
        ref_pending <= 1'b1;
        if (ref_pending) refresh_overrun <= 1'b1;
      end else if (take_refresh) begin
        ref_pending <= 1'b0;
      end

      if (take_refresh) begin
        is_refresh <= 1'b1;
        ctrl_cmd   <= CMD_W'(CMD_REFRESH);
        ctrl_addr  <= '0;
        ctrl_wdata <= '0;
      end

      // Non-memory commands bypass the controller, so its fields stay put.
      if (take_grant) begin
        rr_ptr     <= grant_idx;
        win_idx    <= grant_idx;
        is_refresh <= 1'b0;
        rdata_q    <= '0;
        if (sel_mem) begin
          ctrl_cmd   <= sel_cmd;
          ctrl_addr  <= sel_addr;
          ctrl_wdata <= sel_wdata;
        end
      end

      if (state == ST_WAIT_DONE && ctrl_done && !is_refresh &&
          ctrl_cmd == CMD_W'(CMD_READ))
        rdata_q <= ctrl_rdata;
    end
  end

  assign ctrl_valid = (state == ST_ISSUE);
  assign rsp_done   = (state == ST_RESP) ? (ONE_LSB << win_idx) : '0;
  assign rsp_rdata  = (state == ST_RESP) ? rdata_q : '0;
  // Held low while waiting for init so every output is zero out of reset.
  assign busy       = (state == ST_ISSUE) || (state == ST_WAIT_DONE) || (state == ST_RESP);

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int NR = 4;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int RC = 16;

  typedef struct { logic [3:0] cmd; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  typedef struct { int idx; logic [DW-1:0] data; } rsp_t;

  logic              clk;
  logic              rst, init_comp;
  logic [NR-1:0]     req_valid;
  logic [NR*CW-1:0]  req_cmd;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready, rsp_done;
  logic [DW-1:0]     rsp_rdata;
  logic              ctrl_valid;
  logic [CW-1:0]     ctrl_cmd;
  logic [AW-1:0]     ctrl_addr;
  logic [DW-1:0]     ctrl_wdata;
  logic              ctrl_done;
  logic [DW-1:0]     ctrl_rdata;
  logic              busy, refresh_overrun;

  sdram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW),
                  .REFRESH_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .init_comp(init_comp),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_done(rsp_done),
    .rsp_rdata(rsp_rdata), .ctrl_valid(ctrl_valid), .ctrl_cmd(ctrl_cmd),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_done(ctrl_done),
    .ctrl_rdata(ctrl_rdata), .busy(busy), .refresh_overrun(refresh_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hACDB;
  endfunction

  // shared bench state
  req_t    rq [NR][$];
  rsp_t    rsp_q[$];
  req_t    ctrl_q[$];
  int      grant_log[$];
  logic [NR-1:0] granted_mask = '0;
  bit      inflight_req = 0, pending_rsp_next = 0, exp_valid_next = 0;
  int      refreshes = 0, nonref_valids = 0;
  int      done_delay = 3;
  int      rst_epoch = 0;
  bit      pend_m = 0, overrun_m = 0;

  task automatic push_req(input int i, input logic [3:0] c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    req_t r;
    r.cmd = c; r.addr = a; r.wdata = d;
    rq[i].push_back(r);
  endtask

  // requester drivers + refresh-interval model (acts just after each edge)
  initial begin
    bit active, rst_s, init_s, take, expd;
    int mcnt;
    req_t tmp;
    active = 0; mcnt = RC - 1;
    req_valid = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(posedge clk);
      rst_s = rst; init_s = init_comp;
      #1;
      if (rst_s) begin
        active = 0; mcnt = RC - 1; pend_m = 0; overrun_m = 0;
      end else begin
        take = ctrl_valid && (ctrl_cmd == CMD_REFRESH);
        if (take) check("refresh_when_pending", pend_m, 1);
        expd = active && (mcnt == 0);
        if (active) mcnt = (mcnt == 0) ? RC - 1 : mcnt - 1;
        if (expd && pend_m) overrun_m = 1;
        if (expd) pend_m = 1;
        else if (take) pend_m = 0;
        if (!active && init_s) active = 1;
      end
      for (int i = 0; i < NR; i++) begin
        if (granted_mask[i] && rq[i].size() != 0) tmp = rq[i].pop_front();
        req_valid[i] = (rq[i].size() != 0);
        if (rq[i].size() != 0) begin
          req_cmd[i*CW +: CW]   = rq[i][0].cmd;
          req_addr[i*AW +: AW]  = rq[i][0].addr;
          req_wdata[i*DW +: DW] = rq[i][0].wdata;
        end else begin
          req_cmd[i*CW +: CW] = '0; req_addr[i*AW +: AW] = '0; req_wdata[i*DW +: DW] = '0;
        end
      end
    end
  end

  // controller model: completes each command done_delay cycles after ctrl_valid
  initial begin
    logic [CW-1:0] cap_cmd;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    int ep, d;
    ctrl_done = 1'b0; ctrl_rdata = '0;
    forever begin
      @(negedge clk);
      if (ctrl_valid && !rst) begin
        cap_cmd = ctrl_cmd; cap_addr = ctrl_addr; cap_wdata = ctrl_wdata;
        ep = rst_epoch; d = done_delay;
        repeat (d) @(posedge clk);
        #1;
        if (ep == rst_epoch) begin
          check("ctrl_hold_cmd", ctrl_cmd, cap_cmd);
          check("ctrl_hold_addr", ctrl_addr, cap_addr);
          check("ctrl_hold_wdata", ctrl_wdata, cap_wdata);
        end
        ctrl_done  = 1'b1;
        ctrl_rdata = (cap_cmd == CMD_READ) ? rd_model(cap_addr) : 16'hDEAD;
        @(posedge clk); #1;
        ctrl_done = 1'b0; ctrl_rdata = '0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    bit exp_rsp_now, exp_valid_now;
    int ptr_m, w, c;
    rsp_t r;
    req_t q;
    ptr_m = NR - 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_q.delete(); ctrl_q.delete(); grant_log.delete();
        inflight_req = 0; pending_rsp_next = 0; exp_valid_next = 0;
        granted_mask = '0; ptr_m = NR - 1;
      end else begin
        exp_rsp_now = pending_rsp_next; pending_rsp_next = 0;
        exp_valid_now = exp_valid_next; exp_valid_next = 0;

        check("rsp_timing", rsp_done != '0, exp_rsp_now);
        if (rsp_done != '0) begin
          check("rsp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            check("rsp_done", rsp_done, 64'd1 << r.idx);
            check("rsp_rdata", rsp_rdata, r.data);
          end
        end

        if (exp_valid_now) check("ctrl_valid_latency", ctrl_valid, 1);
        if (ctrl_valid) begin
          check("busy", busy, 1);
          if (ctrl_cmd == CMD_REFRESH) begin
            check("refresh_addr", ctrl_addr, 0);
            refreshes++;
            inflight_req = 0;
          end else begin
            nonref_valids++;
            check("ctrl_expected", ctrl_q.size() != 0, 1);
            if (ctrl_q.size() != 0) begin
              q = ctrl_q.pop_front();
              check("ctrl_cmd", ctrl_cmd, q.cmd);
              check("ctrl_addr", ctrl_addr, q.addr);
              check("ctrl_wdata", ctrl_wdata, q.wdata);
            end
            inflight_req = 1;
          end
        end

        if (ctrl_done && inflight_req) begin
          pending_rsp_next = 1;
          inflight_req = 0;
        end

        if (req_ready != '0) begin
          w = -1;
          for (int k = 1; k <= NR; k++) begin
            c = (ptr_m + k) % NR;
            if (w < 0 && req_valid[c]) w = c;
          end
          check("refresh_first", pend_m, 0);
          if (w < 0) check("grant", req_ready, 0);
          else begin
            check("grant", req_ready, 64'd1 << w);
            q.cmd = req_cmd[w*CW +: CW]; q.addr = req_addr[w*AW +: AW]; q.wdata = req_wdata[w*DW +: DW];
            r.idx = w;
            r.data = (q.cmd == CMD_READ) ? rd_model(q.addr) : '0;
            rsp_q.push_back(r);
            if (q.cmd == CMD_READ || q.cmd == CMD_WRITE) begin
              ctrl_q.push_back(q);
              exp_valid_next = 1;
            end else begin
              pending_rsp_next = 1;
            end
            ptr_m = w;
            grant_log.push_back(w);
          end
        end
        granted_mask = req_ready;
        check("refresh_overrun", refresh_overrun, overrun_m);
      end
    end
  end

  task automatic drain(input int budget, input string tag);
    bit idle;
    idle = 0;
    for (int k = 0; k < budget && !idle; k++) begin
      @(negedge clk); #1;
      idle = !inflight_req && !pending_rsp_next && !exp_valid_next &&
             rsp_q.size() == 0 && ctrl_q.size() == 0;
      for (int i = 0; i < NR; i++) if (rq[i].size() != 0) idle = 0;
    end
    check(tag, idle, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int nv, n;
    bit found;
    rst = 1'b1; init_comp = 1'b0;
    for (int i = 0; i < NR; i++) begin
      push_req(i, CMD_READ,  22'(32'h100 + i), '0);
      push_req(i, CMD_WRITE, 22'(32'h200 + i), 16'(32'h5A00 + i));
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_done", rsp_done, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_ctrl_valid", ctrl_valid, 0);
    check("rst_ctrl_cmd", ctrl_cmd, CMD_NOP);
    check("rst_ctrl_addr", ctrl_addr, 0);
    check("rst_ctrl_wdata", ctrl_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", refresh_overrun, 0);

    // init held low with everyone requesting
    repeat (20) begin
      @(negedge clk);
      check("init_wait_ready", req_ready, 0);
      check("init_wait_valid", ctrl_valid, 0);
    end
    check("init_wait_reqs", req_valid, 4'b1111);
    @(posedge clk); #1 init_comp = 1'b1;
    @(negedge clk);
    check("init_edge_ready", req_ready, 0);
    @(negedge clk);
    check("first_grant", req_ready, 4'b0001);

    drain(600, "drain_rr");
    check("grant_count", grant_log.size(), 8);
    n = (grant_log.size() < 5) ? grant_log.size() : 5;
    for (int k = 0; k < n; k++) check("grant_order", grant_log[k], exp_order[k]);
    check("refresh_seen", refreshes != 0, 1);

    // single read from requester 2
    push_req(2, CMD_READ, 22'h001234, '0);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (rsp_done != '0) begin
        found = 1;
        check("read2_done", rsp_done, 4'b0100);
        check("read2_rdata", rsp_rdata, 16'hBEEF);
      end
    end
    check("read2_seen", found, 1);
    drain(100, "drain_read2");

    // non-memory commands never reach the controller
    nv = nonref_valids;
    push_req(1, CMD_NOP, 22'h000077, 16'h1111);
    push_req(3, 4'hF,    22'h000088, 16'h2222);
    drain(200, "drain_nop");
    check("nop_no_ctrl", nonref_valids, nv);

    // stalled controller -> refresh overrun, sticky afterwards
    check("overrun_before", refresh_overrun, 0);
    done_delay = 40;
    push_req(0, CMD_READ, 22'h000003, '0);
    drain(300, "drain_stall");
    done_delay = 3;
    check("overrun_set", refresh_overrun, 1);
    for (int i = 0; i < NR; i++) push_req(i, CMD_WRITE, 22'(32'h300 + i), 16'(32'hC0 + i));
    drain(600, "drain_after_stall");
    check("overrun_sticky", refresh_overrun, 1);

    // reset while waiting on the controller
    done_delay = 10;
    push_req(0, CMD_READ, 22'h000055, '0);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (ctrl_valid && ctrl_cmd == CMD_READ) found = 1;
    end
    check("rst_test_issue", found, 1);
    @(posedge clk); #1;
    rst = 1'b1; init_comp = 1'b0; rst_epoch++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ctrl_valid", ctrl_valid, 0);
    check("midrst_ctrl_cmd", ctrl_cmd, CMD_NOP);
    check("midrst_ctrl_addr", ctrl_addr, 0);
    check("midrst_rsp_done", rsp_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", refresh_overrun, 0);
    repeat (20) begin
      @(negedge clk);
      check("post_rst_valid", ctrl_valid, 0);
      check("post_rst_rsp", rsp_done, 0);
      check("post_rst_ready", req_ready, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller between up to NUM_REQ requesters (particle read, particle write, display, host) in the grav_sim memory subsystem. Sits between requester ports and the controller command interface, replacing the fixed command list once init completes. Round-robin grant among requesters, with periodic auto-refresh inserted at highest priority. One command outstanding at the controller at any time.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 22, SDRAM word address width
- DATA_W, 16, SDRAM data width
- CMD_W, 4, command code width (matches controller)
- REFRESH_CYCLES, 780, clk cycles between refresh requests (>= 16)

- clk  in  1  clock; everything on rising edge
- rst  in  1  reset, synchronous, active-high
- init_comp  in  1  controller power-up init finished (level)
- req_valid  in  NUM_REQ  requester i has a command pending
- req_cmd  in  NUM_REQ*CMD_W  requester i command at [i*CMD_W +: CMD_W]
- req_addr  in  NUM_REQ*ADDR_W  requester i address, same packing
- req_wdata  in  NUM_REQ*DATA_W  requester i write data, same packing
- req_ready  out  NUM_REQ  one-hot; request i captured this cycle
- rsp_done  out  NUM_REQ  one-hot 1-cycle pulse; requester i command complete
- rsp_rdata  out  DATA_W  read data, valid with rsp_done
- ctrl_valid  out  1  1-cycle command strobe to controller
- ctrl_cmd / ctrl_addr / ctrl_wdata  out  CMD_W / ADDR_W / DATA_W  command fields, held stable from ctrl_valid until ctrl_done
- ctrl_done  in  1  controller completion pulse
- ctrl_rdata  in  DATA_W  controller read data, valid with ctrl_done
- busy  out  1  state != IDLE
- refresh_overrun  out  1  sticky: refresh interval expired with refresh still pending

## Operation
- States: WAIT_INIT, IDLE, ISSUE, WAIT_DONE, RESP.
- Reset: state WAIT_INIT; all outputs 0 (ctrl_cmd = CMD_NOP); RR pointer = NUM_REQ-1 (requester 0 wins first); refresh counter = REFRESH_CYCLES-1; refresh_pending = 0.
- WAIT_INIT -> IDLE when init_comp = 1. init_comp ignored after that; re-init requires rst.
- Refresh counter decrements every cycle outside WAIT_INIT; at 0 sets refresh_pending and reloads REFRESH_CYCLES-1. Expiry while refresh_pending already 1 sets refresh_overrun.
- IDLE priority: refresh_pending first -> latch CMD_REFRESH, addr 0, clear refresh_pending, go ISSUE (no req_ready, no rsp_done). Else RR search from pointer+1 mod NUM_REQ over req_valid; winner w: req_ready[w] = 1 (combinational in IDLE), fields latched, pointer = w.
- Winner cmd CMD_READ or CMD_WRITE -> ISSUE. Any other code -> RESP directly (controller untouched, rsp_rdata = 0).
- ISSUE: ctrl_valid = 1 one cycle -> WAIT_DONE.
- WAIT_DONE: wait for ctrl_done; latch ctrl_rdata (reads) -> RESP for requester commands, -> IDLE for refresh. ctrl_done outside WAIT_DONE ignored.
- RESP: rsp_done[w] = 1, rsp_rdata valid one cycle -> IDLE.
- Requester may change or drop req_valid the cycle after req_ready; dropping req_valid before grant is legal (no grant).
- Refresh expiry coinciding with a grant in IDLE: grant proceeds; refresh taken at next IDLE.

## Timing
- Grant in IDLE at edge N; ctrl_valid high cycle N+1; WAIT_DONE from N+2.
- ctrl_done sampled at edge M (M >= N+2) -> rsp_done high cycle M+1 -> IDLE cycle M+2.
- Refresh: ctrl_done at M -> IDLE cycle M+1.
- Non-memory command: req_ready cycle N, rsp_done cycle N+1.
- rst mid-operation: next cycle state WAIT_INIT, outstanding command abandoned, no rsp_done.

## Structure
- sdram_pkg: CMD_NOP=4'b0000, CMD_READ=4'b0001, CMD_WRITE=4'b0010, CMD_REFRESH=4'b0011; state encoding; shared with controller and command sequencer.
- Sub-module rr_arbiter (parameter NUM_REQ; req vector, pointer -> one-hot grant, grant index, any_grant), combinational.

## Test plan
- Reset, init_comp held 0 for 20 cycles with req_valid=4'b1111 -> no req_ready, ctrl_valid 0; raise init_comp -> req_ready=4'b0001 two cycles later.
- All four requesting continuously, ctrl_done 3 cycles after each ctrl_valid -> grant order 0,1,2,3,0; each rsp_done one-hot to matching requester.
- Requester 2 READ addr 0x1234, ctrl_rdata 0xBEEF with ctrl_done -> rsp_done=4'b0100, rsp_rdata=0xBEEF next cycle.
- REFRESH_CYCLES=16, continuous traffic -> CMD_REFRESH issued at first IDLE after each expiry; no rsp_done for it; stall ctrl_done 40 cycles -> refresh_overrun=1 and stays 1.
- Requester 1 issues CMD_NOP -> req_ready[1] then rsp_done[1] next cycle, ctrl_valid never asserted.
- rst asserted in WAIT_DONE -> all outputs 0, state WAIT_INIT, later ctrl_done ignored, no rsp_done.
